// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit, grouped for port passing.
// slave is the lsu side; master is the execute stage plus memory side.
interface lsu_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  done;
    logic                  err;
    logic [31:0]           rdata;
    logic [ADDR_WIDTH-3:0] dm_addr;
    logic [31:0]           dm_wdata;
    logic                  dm_we;
    logic                  dm_re;
    logic [31:0]           dm_rdata;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
        output req_ready, done, err, rdata, dm_addr, dm_wdata, dm_we, dm_re
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, dm_rdata,
        input  req_ready, done, err, rdata, dm_addr, dm_wdata, dm_we, dm_re
    );
endinterface

// File: rtl/lsu.sv
// Big-endian load/store unit in front of a word-only memory: sub-word stores use
// read-modify-write, sub-word loads are sign/zero-extended.
module lsu #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StDone} state_e;

    state_e                state_q;
    logic                  store_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH-3:0] dm_addr_q;
    logic [31:0]           dm_wdata_q;
    logic [31:0]           rdata_q;
    logic                  done_q;
    logic                  err_q;
    logic                  dm_we_q;
    logic                  dm_re_q;

    logic                  req_bad;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_ext;
    logic [31:0]           st_merge;

    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Offset 0 is the most significant byte.
    always_comb begin
        ld_byte = 8'h00;
        case (off_q)
            2'd0:    ld_byte = bus.dm_rdata[31:24];
            2'd1:    ld_byte = bus.dm_rdata[23:16];
            2'd2:    ld_byte = bus.dm_rdata[15:8];
            default: ld_byte = bus.dm_rdata[7:0];
        endcase
        ld_half = off_q[1] ? bus.dm_rdata[15:0] : bus.dm_rdata[31:16];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus.dm_rdata;
        endcase
    end

    always_comb begin
        st_merge = bus.dm_rdata;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    st_merge[31:24] = wdata_q[7:0];
                2'd1:    st_merge[23:16] = wdata_q[7:0];
                2'd2:    st_merge[15:8]  = wdata_q[7:0];
                default: st_merge[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            st_merge[15:0] = wdata_q[15:0];
        end else begin
            st_merge[31:16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            store_q    <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            dm_addr_q  <= '0;
            dm_wdata_q <= 32'h0;
            rdata_q    <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dm_we_q <= 1'b0;
            dm_re_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        store_q   <= bus.req_store;
                        uns_q     <= bus.req_unsigned;
                        size_q    <= bus.req_size;
                        off_q     <= bus.req_addr[1:0];
                        wdata_q   <= bus.req_wdata;
                        dm_addr_q <= bus.req_addr[ADDR_WIDTH-1:2];
                        if (req_bad) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (!bus.req_store) begin
                            state_q <= StLoad;
                            dm_re_q <= 1'b1;
                        end else if (bus.req_size == 2'b10) begin
                            state_q    <= StWrite;
                            dm_we_q    <= 1'b1;
                            dm_wdata_q <= bus.req_wdata;
                        end else begin
                            state_q <= StRmwRd;
                            dm_re_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    rdata_q <= ld_ext;
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StRmwRd: begin
                    dm_wdata_q <= st_merge;
                    state_q    <= StWrite;
                    dm_we_q    <= 1'b1;
                end
                StWrite: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gating with rst keeps strobes low during a reset cycle, so an aborted write never lands.
    assign bus.req_ready = (state_q == StIdle) & ~rst;
    assign bus.done      = done_q & ~rst;
    assign bus.err       = err_q & ~rst;
    assign bus.dm_we     = dm_we_q & ~rst;
    assign bus.dm_re     = dm_re_q & ~rst;
    assign bus.rdata     = rdata_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_wdata  = dm_wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a word memory model with combinational read.
module tb_lsu;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_WIDTH(AW)) bus ();
    lsu #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[1] <= 32'h8822F344;
        end else if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wdata;
        end
    end
    assign bus.dm_rdata = mem[bus.dm_addr];

    int we_cnt = 0;
    int re_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (bus.dm_we) we_cnt++;
        if (bus.dm_re) re_cnt++;
        if (bus.done) done_cnt++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic st, input logic [1:0] sz, input logic un,
                          input logic [AW-1:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic exp_err, input int exp_we, input int exp_re);
        int w, lat, we0, re0, busy;
        logic got, e;
        @(negedge clk);
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        we0 = we_cnt;
        re0 = re_cnt;
        busy = 0;
        got = 1'b0;
        e = 1'b0;
        lat = 0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.req_ready) busy++;
            if (bus.done) begin
                got = 1'b1;
                e = bus.err;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(e), 32'(exp_err));
        check({tag, " ready while busy"}, 32'(busy), 32'd0);
        check({tag, " we pulses"}, 32'(we_cnt - we0), 32'(exp_we));
        check({tag, " re cycles"}, 32'(re_cnt - re0), 32'(exp_re));
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.req_ready), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset we", 32'(bus.dm_we), 32'd0);
        check("reset re", 32'(bus.dm_re), 32'd0);
        check("reset rdata", bus.rdata, 32'h0);
        check("reset dm_addr", 32'(bus.dm_addr), 32'h0);
        check("reset dm_wdata", bus.dm_wdata, 32'h0);
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b0;

        // Loads from word 1 = 0x8822F344
        do_req("LB 4", 1'b0, 2'b00, 1'b0, 10'd4, 32'h0, 2, 1'b0, 0, 1);
        check("LB 4 rdata", bus.rdata, 32'hFFFFFF88);
        do_req("LBU 4", 1'b0, 2'b00, 1'b1, 10'd4, 32'h0, 2, 1'b0, 0, 1);
        check("LBU 4 rdata", bus.rdata, 32'h00000088);
        do_req("LH 6", 1'b0, 2'b01, 1'b0, 10'd6, 32'h0, 2, 1'b0, 0, 1);
        check("LH 6 rdata", bus.rdata, 32'hFFFFF344);
        do_req("LHU 6", 1'b0, 2'b01, 1'b1, 10'd6, 32'h0, 2, 1'b0, 0, 1);
        check("LHU 6 rdata", bus.rdata, 32'h0000F344);
        do_req("LW 4", 1'b0, 2'b10, 1'b0, 10'd4, 32'h0, 2, 1'b0, 0, 1);
        check("LW 4 rdata", bus.rdata, 32'h8822F344);

        // Stores
        do_req("SB 5", 1'b1, 2'b00, 1'b0, 10'd5, 32'h000000AB, 3, 1'b0, 1, 1);
        check("SB 5 mem", mem[1], 32'h88ABF344);
        do_req("SH 6", 1'b1, 2'b01, 1'b0, 10'd6, 32'h00001234, 3, 1'b0, 1, 1);
        check("SH 6 mem", mem[1], 32'h88AB1234);
        do_req("SW 8", 1'b1, 2'b10, 1'b0, 10'd8, 32'hDEADBEEF, 2, 1'b0, 1, 0);
        check("SW 8 mem", mem[2], 32'hDEADBEEF);
        check("rdata held over stores", bus.rdata, 32'h8822F344);

        // Errors
        do_req("LW 6 err", 1'b0, 2'b10, 1'b0, 10'd6, 32'h0, 1, 1'b1, 0, 0);
        do_req("SH 3 err", 1'b1, 2'b01, 1'b0, 10'd3, 32'h0000FFFF, 1, 1'b1, 0, 0);
        do_req("size11 err", 1'b0, 2'b11, 1'b0, 10'd0, 32'h0, 1, 1'b1, 0, 0);
        check("rdata held over errors", bus.rdata, 32'h8822F344);
        check("err mem0", mem[0], 32'h0);
        check("err mem1", mem[1], 32'h88AB1234);

        // Two queued loads with req_valid held high
        @(negedge clk);
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b1;
        bus.req_addr     = 10'd7;
        bus.req_valid    = 1'b1;
        check("q1 ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_size     = 2'b01;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 10'd4;
        @(negedge clk);
        check("q LOAD ready", 32'(bus.req_ready), 32'd0);
        check("q LOAD re", 32'(bus.dm_re), 32'd1);
        @(negedge clk);
        check("q DONE ready", 32'(bus.req_ready), 32'd0);
        check("q DONE done", 32'(bus.done), 32'd1);
        check("q1 rdata", bus.rdata, 32'h00000034);
        @(negedge clk);
        check("q IDLE ready", 32'(bus.req_ready), 32'd1);
        check("q IDLE done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("q2 LOAD re", 32'(bus.dm_re), 32'd1);
        @(negedge clk);
        check("q2 done", 32'(bus.done), 32'd1);
        check("q2 rdata", bus.rdata, 32'hFFFF88AB);

        // Reset during the WRITE cycle of SB 9
        @(negedge clk);
        bus.req_store = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 10'd9;
        bus.req_wdata = 32'h00000055;
        bus.req_valid = 1'b1;
        check("rst SB ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst SB rmw re", 32'(bus.dm_re), 32'd1);
        @(negedge clk);
        check("rst SB reached write", 32'(bus.dm_we), 32'd1);
        begin
            int d0;
            d0 = done_cnt;
            rst = 1'b1;
            #1;
            check("rst SB we gated", 32'(bus.dm_we), 32'd0);
            check("rst SB ready low", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("rst SB ready after", 32'(bus.req_ready), 32'd1);
            check("rst SB rdata cleared", bus.rdata, 32'h0);
            repeat (3) @(negedge clk);
            check("rst SB no done", 32'(done_cnt - d0), 32'd0);
            check("rst SB mem2", mem[2], 32'hDEADBEEF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly upstream of the word-only data memory (dm).
- Accepts byte-addressed load/store requests of byte, halfword or word size from the execute stage.
- Drives dm's 8-bit word address, write data, write enable and read enable; performs read-modify-write for sub-word stores; sign/zero-extends sub-word loads.
- Big-endian byte order: byte offset 0 maps to bits [31:24].

Parameters:
- ADDR_WIDTH, 10: byte address width. dm word address is addr[ADDR_WIDTH-1:2], which is 8 bits at the default.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present; held stable until accepted.
- req_ready  output  1  unit can accept a request; high only in IDLE while rst=0.
- req_store  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1=misaligned or illegal size, no memory access made.
- rdata  output  32  extended load result; updated only on successful load completion.
- dm_addr  output  ADDR_WIDTH-2  word address to dm.
- dm_wdata  output  32  word to dm data_in.
- dm_we  output  1  to dm write_enable.
- dm_re  output  1  to dm read_enable.
- dm_rdata  input  32  from dm data_out; combinational from dm_addr/dm_re.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; done=0, err=0, rdata=0, dm_addr=0, dm_wdata=0, dm_we=0, dm_re=0, req_ready=0 while rst=1.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. On acceptance the unit latches store, size, unsigned, addr and wdata. Inputs are ignored at all other times.
- States and transitions after acceptance:
  - If size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠00, go to DONE with err=1.
  - Otherwise a load goes to LOAD.
  - A word store goes to WRITE.
  - A byte or half store goes to RMW_RD.
- LOAD:
  - dm_re=1, dm_addr=latched word address.
  - On the next edge, capture the extracted and extended result into rdata, then go to DONE with err=0.
- RMW_RD:
  - dm_re=1.
  - On the next edge, merge the store lanes into dm_rdata and hold the result in the merge register, then go to WRITE.
  - Byte lanes by offset: off0=[31:24], off1=[23:16], off2=[15:8], off3=[7:0].
  - Half lanes: addr[1]=0 selects [31:16], addr[1]=1 selects [15:0].
- WRITE:
  - dm_we=1 for exactly one cycle, dm_wdata=merged word (word store: latched wdata).
  - Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- IDLE: req_ready=1.
- dm_re and dm_we are high only in their states, and are forced 0 in any cycle with rst=1. No dm write occurs at an edge where rst=1.
- Latency from the accept edge to the done-high cycle:
  - load or word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Exactly one dm_we pulse per successful store; zero for loads and errors.
- rdata holds its value across stores, errors and idle cycles.
- Reset mid-operation: abort immediately. No partial write is performed. The state is IDLE in the cycle after the reset edge, and req_ready=1 once rst=0.
- No back-to-back overlap: the next request is accepted at the earliest on the edge following the first IDLE cycle.

Test Plan:
- Word 1 preloaded with 0x8822F344. Loads at addr 4/4/6/6/4 (LB, LBU, LH, LHU, LW) -> rdata = 0xFFFFFF88, 0x00000088, 0xFFFFF344, 0x0000F344, 0x8822F344. Each load gives done 2 cycles after accept, err=0, dm_we never high.
- SB addr 5, wdata 0x000000AB onto 0x8822F344 -> word 1 = 0x88ABF344. done 3 cycles after accept, exactly one dm_we pulse. A following SH addr 6, wdata 0x00001234 -> 0x88AB1234.
- SW addr 8, wdata 0xDEADBEEF -> word 2 = 0xDEADBEEF, done 2 cycles after accept, no dm_re cycle.
- LW addr 6, SH addr 3 and size=11 at addr 0 -> each gives done 1 cycle after accept with err=1. dm_re=dm_we=0 throughout, rdata unchanged, memory unchanged.
- SB addr 9 with rst asserted during the WRITE cycle -> dm_we=0 at that edge, word 2 unchanged, done never pulses, req_ready=1 in the first cycle after rst deasserts.
- req_valid held high with two queued loads -> the second is accepted only after DONE→IDLE, and req_ready is low during LOAD and DONE.
